// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: core/peripheral signal bundle for the interrupt controller.
// slave = controller side, master = core/peripheral side.
interface intr_ctrl_if #(
    parameter int unsigned TIMER_W = 32
);
    logic               rx_valid;
    logic               intr_en;
    logic               ack;
    logic               insn_boundary;
    logic               icall_taken;
    logic               period_we;
    logic [TIMER_W-1:0] period_wdata;
    logic               icall_req;
    logic               intr_cause;
    logic [1:0]         pending;
    logic               overrun;

    modport slave (
        input  rx_valid,
        input  intr_en,
        input  ack,
        input  insn_boundary,
        input  icall_taken,
        input  period_we,
        input  period_wdata,
        output icall_req,
        output intr_cause,
        output pending,
        output overrun
    );

    modport master (
        output rx_valid,
        output intr_en,
        output ack,
        output insn_boundary,
        output icall_taken,
        output period_we,
        output period_wdata,
        input  icall_req,
        input  intr_cause,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: pending latch, fixed rx>timer priority and ICALL request FSM.
// Timer source is built only when INTR_TIMER_EN is defined.
module intr_ctrl #(
    parameter int unsigned TIMER_W      = 32,
    parameter int unsigned RESET_PERIOD = 0
) (
    input logic        clk,
    input logic        rst_n,
    intr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] pend_q, pend_d;
    logic       ovr_q, ovr_d;
    logic       cause_q, cause_d;
    logic       tmr_exp;
    logic       ack_svc;
    logic [1:0] set_vec;
    logic [1:0] clr_vec;

`ifdef INTR_TIMER_EN
    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        tmr_exp  = 1'b0;
        if (period_q != '0) begin
            if (cnt_q == TIMER_W'(1)) begin
                tmr_exp = 1'b1;
                cnt_d   = period_q;
            end else if (cnt_q == '0) begin
                cnt_d = period_q;
            end else begin
                cnt_d = cnt_q - TIMER_W'(1);
            end
        end
        // a write reloads the counter but an expiry this cycle still fires
        if (bus.period_we) begin
            period_d = bus.period_wdata;
            cnt_d    = bus.period_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= TIMER_W'(RESET_PERIOD);
            cnt_q    <= TIMER_W'(RESET_PERIOD);
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic unused_period;
    assign unused_period = ^{bus.period_we, bus.period_wdata,
                             TIMER_W[0], RESET_PERIOD[0]};
    assign tmr_exp = 1'b0;
`endif

    assign ack_svc = (state_q == SERVICE) && bus.ack;
    assign set_vec = {tmr_exp, bus.rx_valid};
    assign clr_vec = ack_svc ? (cause_q ? 2'b10 : 2'b01) : 2'b00;

    // a set colliding with its own clear wins and is not an overrun
    always_comb begin
        pend_d = (pend_q & ~clr_vec) | set_vec;
        ovr_d  = ovr_q;
        if (|(set_vec & pend_q & ~clr_vec)) begin
            ovr_d = 1'b1;
        end else if (ack_svc) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (bus.intr_en && (pend_q != 2'b00) && bus.insn_boundary) begin
                    state_d = REQ;
                    cause_d = ~pend_q[0];
                end
            end
            REQ: begin
                if (bus.icall_taken) begin
                    state_d = SERVICE;
                end else if (!bus.intr_en) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            ovr_q   <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cause_q <= cause_d;
        end
    end

    assign bus.icall_req  = (state_q == REQ);
    assign bus.intr_cause = cause_q;
    assign bus.pending    = pend_q;
    assign bus.overrun    = ovr_q;
endmodule
